harvard_data_ram: RTL and testbench

HARVARD_DATA_RAM -- requirements
Module: harvard_data_ram

---
 rtl/harvard_data_ram.sv | 91 +++++++++
 tb/tb_harvard_data_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/harvard_data_ram.sv
// Single-port data RAM with byte-lane writes and a registered read path.
// After reset it zeroes every word, one per cycle, before taking requests.
module harvard_data_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ACK,
  output logic                ERR,
  output logic                BUSY
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       clr_cnt;
  logic [IDX_W-1:0]       idx, clr_idx;
  logic                   in_range, wr_en;
  logic [NB-1:0][7:0]     rd_word;

  assign in_range = {1'b0, ADDR} < DEPTH_X;
  assign idx      = ADDR[IDX_W-1:0];
  assign clr_idx  = clr_cnt[IDX_W-1:0];
  assign wr_en    = (state == IDLE) && REQ && WE && in_range;

  // One byte-wide array per lane so BE maps straight onto lane write enables.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
      if (RST_N) begin
        if (state == INIT)
          mem[clr_idx] <= '0;
        else if (wr_en && BE[b])
          mem[idx] <= WDATA[8*b +: 8];
      end
    end

    assign rd_word[b] = mem[idx];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= INIT;
      clr_cnt <= '0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= '0;
      BUSY    <= 1'b1;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_CNT) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        IDLE: begin
          if (REQ) begin
            ACK <= 1'b1;
            // Out-of-range accesses report an error and return zero, write or read.
            if (!in_range) begin
              ERR   <= 1'b1;
              RDATA <= '0;
            end else if (!WE) begin
              RDATA <= rd_word;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harvard_data_ram.sv
// Randomized + directed bench for harvard_data_ram against a word-array model.
module tb_harvard_data_ram;

  logic        CLK = 1'b0;
  logic        RST_N, REQ, WE;
  logic [7:0]  ADDR;
  logic [1:0]  BE;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        ACK, ERR, BUSY;

  harvard_data_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .BE(BE),
    .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [15:0] mmem [64];
  int          clear_left;
  logic [15:0] exp_rd;
  logic        exp_ack, exp_err, exp_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic req, input logic we,
                            input logic [7:0] addr, input logic [1:0] be,
                            input logic [15:0] wd);
    if (!rst) begin
      clear_left = 64;
      exp_ack = 0; exp_err = 0; exp_rd = 0; exp_busy = 1;
      foreach (mmem[i]) mmem[i] = 16'h0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_busy = (clear_left > 0);
      exp_ack = 0; exp_err = 0;
    end else if (req) begin
      exp_ack = 1;
      if (addr >= 64) begin
        exp_err = 1; exp_rd = 0;
      end else begin
        exp_err = 0;
        if (we) begin
          if (be[0]) mmem[addr][7:0]  = wd[7:0];
          if (be[1]) mmem[addr][15:8] = wd[15:8];
        end else begin
          exp_rd = mmem[addr];
        end
      end
    end else begin
      exp_ack = 0; exp_err = 0;
    end
  endtask

  // One clock: drive, let the edge happen, update model, compare just after.
  task automatic cyc(input logic rst, input logic req, input logic we,
                     input logic [7:0] addr, input logic [1:0] be, input logic [15:0] wd);
    RST_N = rst; REQ = req; WE = we; ADDR = addr; BE = be; WDATA = wd;
    @(posedge CLK);
    model_edge(rst, req, we, addr, be, wd);
    #1;
    chk("ack",   {31'b0, ACK},  {31'b0, exp_ack});
    chk("err",   {31'b0, ERR},  {31'b0, exp_err});
    chk("busy",  {31'b0, BUSY}, {31'b0, exp_busy});
    chk("rdata", {16'b0, RDATA}, {16'b0, exp_rd});
  endtask

  task automatic idle();
    cyc(1, 0, 0, 8'h00, 2'b00, 16'h0000);
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] be, input logic [15:0] d);
    cyc(1, 1, 1, a, be, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1, 1, 0, a, 2'b00, 16'h0000);
  endtask

  // Reset, then count cycles with BUSY high (bounded).
  task automatic reset_and_clear(output int n);
    cyc(0, 0, 0, 8'h00, 2'b00, 16'h0000);
    cyc(0, 0, 0, 8'h00, 2'b00, 16'h0000);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    RST_N = 0; REQ = 0; WE = 0; ADDR = 0; BE = 0; WDATA = 0;
    clear_left = 64; exp_ack = 0; exp_err = 0; exp_rd = 0; exp_busy = 1;
    foreach (mmem[i]) mmem[i] = 16'h0;

    // reset state and clear length
    cyc(0, 0, 0, 8'h00, 2'b00, 16'h0000);
    chk("rst_busy",  {31'b0, BUSY},  32'd1);
    chk("rst_ack",   {31'b0, ACK},   32'd0);
    chk("rst_rdata", {16'b0, RDATA}, 32'd0);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      idle();
      n++;
    end
    chk("busy_len", n, 64);
    rd(8'h3F);
    chk("rd_3f", {16'b0, RDATA}, 32'h0);
    chk("rd_3f_ack", {31'b0, ACK}, 32'd1);

    // byte lanes
    wr(8'h05, 2'b11, 16'hABCD);
    wr(8'h05, 2'b01, 16'h0012);
    rd(8'h05);
    chk("lane_rd", {16'b0, RDATA}, 32'hAB12);
    chk("lane_ack", {31'b0, ACK}, 32'd1);
    chk("lane_err", {31'b0, ERR}, 32'd0);
    wr(8'h05, 2'b00, 16'hFFFF);
    rd(8'h05);
    chk("be0_rd", {16'b0, RDATA}, 32'hAB12);

    // back-to-back
    wr(8'h10, 2'b11, 16'h1234);
    chk("b2b_ack0", {31'b0, ACK}, 32'd1);
    rd(8'h10);
    chk("b2b_ack1", {31'b0, ACK}, 32'd1);
    chk("b2b_rd", {16'b0, RDATA}, 32'h1234);
    idle();
    chk("hold_rd", {16'b0, RDATA}, 32'h1234);
    chk("hold_ack", {31'b0, ACK}, 32'd0);

    // out-of-range
    wr(8'h00, 2'b11, 16'h1111);
    wr(8'h40, 2'b11, 16'hFFFF);
    chk("oor_w_err", {31'b0, ERR}, 32'd1);
    chk("oor_w_rd", {16'b0, RDATA}, 32'h0);
    rd(8'h40);
    chk("oor_r_ack", {31'b0, ACK}, 32'd1);
    chk("oor_r_err", {31'b0, ERR}, 32'd1);
    chk("oor_r_rd", {16'b0, RDATA}, 32'h0);
    rd(8'h00);
    chk("oor_w00", {16'b0, RDATA}, 32'h1111);

    // request during clear
    cyc(0, 0, 0, 8'h00, 2'b00, 16'h0000);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      if (n == 9) begin
        wr(8'h07, 2'b11, 16'hBEEF);
        chk("init_req_ack", {31'b0, ACK}, 32'd0);
      end else begin
        idle();
      end
      n++;
    end
    chk("init_req_len", n, 64);
    rd(8'h07);
    chk("init_req_mem", {16'b0, RDATA}, 32'h0);

    // reset mid-traffic
    wr(8'h20, 2'b11, 16'h5555);
    rd(8'h20);
    chk("pre_rst_rd", {16'b0, RDATA}, 32'h5555);
    cyc(0, 1, 0, 8'h20, 2'b00, 16'h0000);
    chk("mid_rst_ack", {31'b0, ACK}, 32'd0);
    chk("mid_rst_busy", {31'b0, BUSY}, 32'd1);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      idle();
      n++;
    end
    chk("mid_rst_len", n, 64);
    rd(8'h20);
    chk("mid_rst_rd", {16'b0, RDATA}, 32'h0);

    // random traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic rst_r;
      rst_r = ($urandom_range(0, 299) != 0);
      cyc(rst_r, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
          8'($urandom_range(0, 79)), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    reset_and_clear(n);
    chk("final_len", n, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
